// File: rtl/traffic_time_pkg.sv
// Shared constants for the traffic phase BCD timer: FSM encoding, digit limits
// and the preset clamp helper.
package traffic_time_pkg;

   localparam int BCD_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [BCD_W-1:0] ONES_MAX     = 4'd9;

   // Saturate an out-of-range preset digit to the largest legal value.
   function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] i_d,
                                                    input logic [BCD_W-1:0] i_lim);
      clamp_digit = (i_d > i_lim) ? i_lim : i_d;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: wraps 0 -> max and borrows from the next
// digit up when decremented at zero.
module bcd_digit_down
   import traffic_time_pkg::*;
(
   input  logic [BCD_W-1:0] i_digit,
   input  logic [BCD_W-1:0] i_max,
   input  logic             i_dec,
   output logic [BCD_W-1:0] o_next,
   output logic             o_borrow
);

   logic w_zero;

   assign w_zero = (i_digit == 4'd0);

   // Decrement with wrap to the digit's maximum on underflow.
   always_comb begin
      o_next   = i_digit;
      o_borrow = 1'b0;
      if (i_dec) begin
         o_borrow = w_zero;
         o_next   = w_zero ? i_max : (i_digit - 4'd1);
      end else begin
         o_next   = i_digit;
         o_borrow = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD MM:SS phase countdown timer with load/start/pause control and a done pulse.
// Optional build macro TRAFFIC_AUTO_RELOAD_EN reloads the shadow preset at 00:00.
module bcd_countdown_timer
   import traffic_time_pkg::*;
#(
   parameter logic [BCD_W-1:0] MIN_TENS_MAX = 4'd5
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_tick_1s,
   input  logic             i_load,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic [BCD_W-1:0] i_preset_m10,
   input  logic [BCD_W-1:0] i_preset_m1,
   input  logic [BCD_W-1:0] i_preset_s10,
   input  logic [BCD_W-1:0] i_preset_s1,
   output logic [BCD_W-1:0] o_min_10,
   output logic [BCD_W-1:0] o_min1,
   output logic [BCD_W-1:0] o_sec_10,
   output logic [BCD_W-1:0] o_sec1,
   output logic             o_busy,
   output logic             o_done
);

   logic [1:0]       r_state;
   logic [BCD_W-1:0] r_m10, r_m1, r_s10, r_s1;
   logic             r_busy, r_done;

   logic [1:0]       w_nxt_state;
   logic [BCD_W-1:0] w_nxt_m10, w_nxt_m1, w_nxt_s10, w_nxt_s1;
   logic             w_nxt_busy, w_nxt_done;

   logic [BCD_W-1:0] w_ld_m10, w_ld_m1, w_ld_s10, w_ld_s1;
   logic [BCD_W-1:0] w_dec_m10, w_dec_m1, w_dec_s10, w_dec_s1;
   logic             w_s1_borrow, w_s10_borrow, w_m1_borrow, w_m10_borrow;
   logic             w_cnt_zero, w_cnt_one;

   assign w_ld_m10 = clamp_digit(i_preset_m10, MIN_TENS_MAX);
   assign w_ld_m1  = clamp_digit(i_preset_m1,  ONES_MAX);
   assign w_ld_s10 = clamp_digit(i_preset_s10, SEC_TENS_MAX);
   assign w_ld_s1  = clamp_digit(i_preset_s1,  ONES_MAX);

   assign w_cnt_zero = ({r_m10, r_m1, r_s10, r_s1} == 16'h0000);
   assign w_cnt_one  = ({r_m10, r_m1, r_s10, r_s1} == 16'h0001);

   bcd_digit_down u_s1 (
      .i_digit (r_s1),  .i_max (ONES_MAX),     .i_dec (1'b1),
      .o_next  (w_dec_s1),  .o_borrow (w_s1_borrow)
   );
   bcd_digit_down u_s10 (
      .i_digit (r_s10), .i_max (SEC_TENS_MAX), .i_dec (w_s1_borrow),
      .o_next  (w_dec_s10), .o_borrow (w_s10_borrow)
   );
   bcd_digit_down u_m1 (
      .i_digit (r_m1),  .i_max (ONES_MAX),     .i_dec (w_s10_borrow),
      .o_next  (w_dec_m1),  .o_borrow (w_m1_borrow)
   );
   bcd_digit_down u_m10 (
      .i_digit (r_m10), .i_max (MIN_TENS_MAX), .i_dec (w_m1_borrow),
      .o_next  (w_dec_m10), .o_borrow (w_m10_borrow)
   );

`ifdef TRAFFIC_AUTO_RELOAD_EN
   logic [BCD_W-1:0] r_sh_m10, r_sh_m1, r_sh_s10, r_sh_s1;
   logic             w_sh_zero;

   assign w_sh_zero = ({r_sh_m10, r_sh_m1, r_sh_s10, r_sh_s1} == 16'h0000);

   // Shadow copy of the last clamped preset, used for automatic reload.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sh_m10 <= 4'd0;
         r_sh_m1  <= 4'd0;
         r_sh_s10 <= 4'd0;
         r_sh_s1  <= 4'd0;
      end else if (i_load) begin
         r_sh_m10 <= w_ld_m10;
         r_sh_m1  <= w_ld_m1;
         r_sh_s10 <= w_ld_s10;
         r_sh_s1  <= w_ld_s1;
      end else begin
         r_sh_m10 <= r_sh_m10;
         r_sh_m1  <= r_sh_m1;
         r_sh_s10 <= r_sh_s10;
         r_sh_s1  <= r_sh_s1;
      end
   end
`endif

   // Next-state logic: load beats start, start beats tick.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_m10   = r_m10;
      w_nxt_m1    = r_m1;
      w_nxt_s10   = r_s10;
      w_nxt_s1    = r_s1;
      w_nxt_done  = 1'b0;
      if (i_load) begin
         w_nxt_state = ST_IDLE;
         w_nxt_m10   = w_ld_m10;
         w_nxt_m1    = w_ld_m1;
         w_nxt_s10   = w_ld_s10;
         w_nxt_s1    = w_ld_s1;
      end else if (i_start) begin
         if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            if (w_cnt_zero) begin
               w_nxt_state = ST_DONE;
               w_nxt_done  = 1'b1;
            end else begin
               w_nxt_state = ST_RUN;
            end
         end else begin
            w_nxt_state = r_state;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_pause) begin
                  w_nxt_state = ST_PAUSE;
               end else if (i_tick_1s) begin
                  if (w_m10_borrow) begin
                     // Already at 00:00 while running: park safely without wrapping.
                     w_nxt_state = ST_DONE;
                  end else if (w_cnt_one) begin
                     w_nxt_done = 1'b1;
`ifdef TRAFFIC_AUTO_RELOAD_EN
                     if (w_sh_zero) begin
                        w_nxt_state = ST_DONE;
                        w_nxt_m10   = 4'd0;
                        w_nxt_m1    = 4'd0;
                        w_nxt_s10   = 4'd0;
                        w_nxt_s1    = 4'd0;
                     end else begin
                        w_nxt_state = ST_RUN;
                        w_nxt_m10   = r_sh_m10;
                        w_nxt_m1    = r_sh_m1;
                        w_nxt_s10   = r_sh_s10;
                        w_nxt_s1    = r_sh_s1;
                     end
`else
                     w_nxt_state = ST_DONE;
                     w_nxt_m10   = w_dec_m10;
                     w_nxt_m1    = w_dec_m1;
                     w_nxt_s10   = w_dec_s10;
                     w_nxt_s1    = w_dec_s1;
`endif
                  end else begin
                     w_nxt_m10 = w_dec_m10;
                     w_nxt_m1  = w_dec_m1;
                     w_nxt_s10 = w_dec_s10;
                     w_nxt_s1  = w_dec_s1;
                  end
               end else begin
                  w_nxt_state = ST_RUN;
               end
            end
            ST_PAUSE: begin
               if (!i_pause) begin
                  w_nxt_state = ST_RUN;
               end else begin
                  w_nxt_state = ST_PAUSE;
               end
            end
            ST_IDLE:  w_nxt_state = ST_IDLE;
            ST_DONE:  w_nxt_state = ST_DONE;
            default:  w_nxt_state = ST_IDLE;
         endcase
      end
   end

   assign w_nxt_busy = (w_nxt_state == ST_RUN) || (w_nxt_state == ST_PAUSE);

   // State, digit and output registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_m10   <= 4'd0;
         r_m1    <= 4'd0;
         r_s10   <= 4'd0;
         r_s1    <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_m10   <= w_nxt_m10;
         r_m1    <= w_nxt_m1;
         r_s10   <= w_nxt_s10;
         r_s1    <= w_nxt_s1;
         r_busy  <= w_nxt_busy;
         r_done  <= w_nxt_done;
      end
   end

   assign o_min_10 = r_m10;
   assign o_min1   = r_m1;
   assign o_sec_10 = r_s10;
   assign o_sec1   = r_s1;
   assign o_busy   = r_busy;
   assign o_done   = r_done;

endmodule
